// File: rtl/pc_fetch_ctrl.sv
// Next-PC and instruction-fetch controller: owns the fetch PC, issues one
// outstanding imem request at a time and queues responses for decode.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign_o,
  output logic [31:0] PC_i,
  output logic        PC_Hold
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic               drop_q, drop_d;
  logic               misalign_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        buf_pc    [BUF_DEPTH];
  logic [31:0]        buf_instr [BUF_DEPTH];
  logic               accept, push, pop, head_bypass;
  logic               req_valid_d, if_valid_d;
  logic [31:0]        if_pc_d, if_instr_d;

  // Next-state, FIFO bookkeeping and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    drop_d      = drop_q;
    misalign_d  = misalign_o;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    push        = 1'b0;
    pop         = if_valid && if_ready;
    accept      = (state_q == S_REQ) && imem_req_valid && imem_req_ready;
    head_bypass = 1'b0;
    if_pc_d     = if_pc;
    if_instr_d  = if_instr;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (accept) begin
          state_d    = S_WAIT;
          fetch_pc_d = fetch_pc_q + 32'd4;
          req_pc_d   = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
          push    = !drop_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect flushes the queue and marks whatever is still in flight as stale
    if (redirect_valid) begin
      push     = 1'b0;
      pop      = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      drop_d   = ((state_q == S_WAIT) && !imem_rsp_valid) || accept;
      state_d  = drop_d ? S_WAIT : S_REQ;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
        fetch_pc_d = fetch_pc_q;
      end else begin
        misalign_d = 1'b0;
        fetch_pc_d = redirect_pc;
      end
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    req_valid_d = (state_d == S_REQ) && (count_d < CNT_W'(BUF_DEPTH)) && !misalign_d;
    if_valid_d  = (count_d != '0);
    head_bypass = push && ((count_q - CNT_W'(pop)) == '0);
    if (if_valid_d) begin
      if (head_bypass) begin
        if_pc_d    = req_pc_q;
        if_instr_d = imem_rsp_data;
      end else begin
        if_pc_d    = buf_pc[rd_ptr_d];
        if_instr_d = buf_instr[rd_ptr_d];
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr_q]    <= req_pc_q;
      buf_instr[wr_ptr_q] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      fetch_pc_q     <= RESET_PC;
      req_pc_q       <= RESET_PC;
      drop_q         <= 1'b0;
      misalign_o     <= 1'b0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= RESET_PC;
      if_valid       <= 1'b0;
      if_instr       <= 32'h0;
      if_pc          <= 32'h0;
      PC_i           <= RESET_PC;
      PC_Hold        <= 1'b1;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      req_pc_q       <= req_pc_d;
      drop_q         <= drop_d;
      misalign_o     <= misalign_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      imem_req_valid <= req_valid_d;
      imem_req_addr  <= fetch_pc_d;
      if_valid       <= if_valid_d;
      if_instr       <= if_instr_d;
      if_pc          <= if_pc_d;
      PC_i           <= fetch_pc_d;
      PC_Hold        <= (fetch_pc_d == fetch_pc_q);
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus a randomized run checked
// against a queue-based transaction model of the fetch unit.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int unsigned DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        misalign_o;
  logic [31:0] PC_i;
  logic        PC_Hold;

  int total = 0;
  int bad   = 0;

  logic [31:0] acc_q  [$];
  logic [63:0] pop_q  [$];
  logic [31:0] hold_q [$];
  bit          rsp_pend = 1'b0;
  logic [31:0] rsp_dat  = 32'h0;

  pc_fetch_ctrl #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .misalign_o(misalign_o), .PC_i(PC_i), .PC_Hold(PC_Hold)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_1234;
  endfunction

  function automatic logic [31:0] acc_at(input int k);
    return (k < acc_q.size()) ? acc_q[k] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [63:0] pop_at(input int k);
    return (k < pop_q.size()) ? pop_q[k] : 64'hxxxx_xxxx_xxxx_xxxx;
  endfunction

  function automatic logic [31:0] hold_at(input int k);
    return (k < hold_q.size()) ? hold_q[k] : 32'hxxxx_xxxx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_q.delete();
    pop_q.delete();
    hold_q.delete();
  endtask

  task automatic apply_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if_ready       = 1'b0;
    rsp_pend       = 1'b0;
    clear_logs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Memory answers one cycle after each accepted request; logs requests, pops, PC writes
  task automatic run(input int n, input bit ifr);
    for (int i = 0; i < n; i++) begin
      imem_rsp_valid = rsp_pend;
      imem_rsp_data  = rsp_dat;
      rsp_pend       = 1'b0;
      imem_req_ready = 1'b1;
      if_ready       = ifr;
      redirect_valid = 1'b0;
      if (imem_req_valid) begin
        acc_q.push_back(imem_req_addr);
        rsp_pend = 1'b1;
        rsp_dat  = mem_word(imem_req_addr);
      end
      if (if_valid && ifr) pop_q.push_back({if_pc, if_instr});
      if (!PC_Hold) hold_q.push_back(PC_i);
      tick();
    end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    if_ready       = 1'b0;
  endtask

  // One redirect cycle; a response due now arrives with it and must be dropped
  task automatic do_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    imem_rsp_valid = rsp_pend;
    imem_rsp_data  = 32'hDEAD_BEEF;
    rsp_pend       = 1'b0;
    imem_req_ready = 1'b0;
    if_ready       = 1'b1;
    tick();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    if_ready       = 1'b0;
  endtask

  task automatic test_reset();
    logic [131:0] got, want;
    reset_n = 1'b0;
    tick();
    got  = {imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, misalign_o, PC_i, PC_Hold};
    want = {1'b0, RST_PC, 1'b0, 32'h0, 32'h0, 1'b0, RST_PC, 1'b1};
    total++;
    if (got !== want) begin bad++; $display("FAIL reset_outputs got=%h want=%h", got, want); end
  endtask

  task automatic test_sequential();
    apply_reset();
    run(12, 1'b1);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (acc_at(k) !== RST_PC + 32'(4 * k)) begin
        bad++; $display("FAIL seq_addr%0d got=%h want=%h", k, acc_at(k), RST_PC + 32'(4 * k));
      end
      total++;
      if (pop_at(k) !== {RST_PC + 32'(4 * k), mem_word(RST_PC + 32'(4 * k))}) begin
        bad++; $display("FAIL seq_pop%0d got=%h want=%h", k, pop_at(k),
                        {RST_PC + 32'(4 * k), mem_word(RST_PC + 32'(4 * k))});
      end
      total++;
      if (hold_at(k) !== RST_PC + 32'(4 * (k + 1))) begin
        bad++; $display("FAIL seq_pc_i%0d got=%h want=%h", k, hold_at(k), RST_PC + 32'(4 * (k + 1)));
      end
    end
    total++;
    if (acc_q.size() != 6 || hold_q.size() != 5) begin
      bad++; $display("FAIL seq_counts got=%0d/%0d want=6/5", acc_q.size(), hold_q.size());
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    run(10, 1'b0);
    total++;
    if (acc_q.size() != 2) begin bad++; $display("FAIL bp_accepts got=%0d want=2", acc_q.size()); end
    total++;
    if ({imem_req_valid, if_valid, if_pc} !== {1'b0, 1'b1, RST_PC}) begin
      bad++; $display("FAIL bp_full got=%b/%b/%h want=0/1/%h", imem_req_valid, if_valid, if_pc, RST_PC);
    end
    run(1, 1'b1);
    run(10, 1'b0);
    total++;
    if (pop_q.size() != 1 || acc_q.size() != 3 || acc_at(2) !== RST_PC + 32'd8) begin
      bad++; $display("FAIL bp_refill got=%0d/%0d/%h want=1/3/%h", pop_q.size(), acc_q.size(), acc_at(2), RST_PC + 32'd8);
    end
    total++;
    if ({imem_req_valid, if_valid, if_pc} !== {1'b0, 1'b1, RST_PC + 32'd4}) begin
      bad++; $display("FAIL bp_refull got=%b/%b/%h want=0/1/%h", imem_req_valid, if_valid, if_pc, RST_PC + 32'd4);
    end
  endtask

  task automatic test_redirect_wait();
    bit seen_stale;
    apply_reset();
    run(2, 1'b1);
    rsp_pend = 1'b0;
    clear_logs();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0100;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    tick();
    redirect_valid = 1'b0;
    total++;
    if ({if_valid, imem_req_valid, PC_Hold, PC_i} !== {1'b0, 1'b0, 1'b0, 32'h0040_0100}) begin
      bad++; $display("FAIL rdw_after got=%b/%b/%b/%h want=0/0/0/00400100", if_valid, imem_req_valid, PC_Hold, PC_i);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    total++;
    if ({if_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h0040_0100}) begin
      bad++; $display("FAIL rdw_resume got=%b/%b/%h want=0/1/00400100", if_valid, imem_req_valid, imem_req_addr);
    end
    run(6, 1'b1);
    total++;
    if (acc_at(0) !== 32'h0040_0100 || pop_at(0) !== {32'h0040_0100, mem_word(32'h0040_0100)}) begin
      bad++; $display("FAIL rdw_first got=%h/%h want=00400100/%h", acc_at(0), pop_at(0), {32'h0040_0100, mem_word(32'h0040_0100)});
    end
    seen_stale = 1'b0;
    foreach (pop_q[k]) if (pop_q[k][31:0] == 32'hDEAD_BEEF) seen_stale = 1'b1;
    total++;
    if (seen_stale) begin bad++; $display("FAIL rdw_stale got=1 want=0"); end
  endtask

  task automatic test_misalign();
    do_redirect(32'h0040_0102);
    total++;
    if ({misalign_o, if_valid} !== 2'b10) begin
      bad++; $display("FAIL mis_set got=%b/%b want=1/0", misalign_o, if_valid);
    end
    clear_logs();
    run(8, 1'b1);
    total++;
    if (acc_q.size() != 0 || imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL mis_stall got=%0d/%b want=0/0", acc_q.size(), imem_req_valid);
    end
    do_redirect(32'h0040_0200);
    total++;
    if (misalign_o !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b want=0", misalign_o); end
    clear_logs();
    run(4, 1'b1);
    total++;
    if (acc_at(0) !== 32'h0040_0200) begin
      bad++; $display("FAIL mis_resume got=%h want=00400200", acc_at(0));
    end
  endtask

  task automatic test_wrap();
    do_redirect(32'hFFFF_FFFC);
    clear_logs();
    run(6, 1'b1);
    total++;
    if (acc_at(0) !== 32'hFFFF_FFFC || acc_at(1) !== 32'h0) begin
      bad++; $display("FAIL wrap_addr got=%h/%h want=fffffffc/00000000", acc_at(0), acc_at(1));
    end
    total++;
    if (hold_at(0) !== 32'hFFFF_FFFC || hold_at(1) !== 32'h0) begin
      bad++; $display("FAIL wrap_pc_i got=%h/%h want=fffffffc/00000000", hold_at(0), hold_at(1));
    end
    total++;
    if (pop_at(1) !== {32'h0, mem_word(32'h0)}) begin
      bad++; $display("FAIL wrap_pop got=%h want=%h", pop_at(1), {32'h0, mem_word(32'h0)});
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [131:0] got, want;
    apply_reset();
    run(2, 1'b1);
    rsp_pend = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    got  = {imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, misalign_o, PC_i, PC_Hold};
    want = {1'b0, RST_PC, 1'b0, 32'h0, 32'h0, 1'b0, RST_PC, 1'b1};
    total++;
    if (got !== want) begin bad++; $display("FAIL async_reset got=%h want=%h", got, want); end
    tick();
    tick();
    reset_n        = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    tick();
    imem_rsp_valid = 1'b0;
    clear_logs();
    run(6, 1'b1);
    total++;
    if (acc_at(0) !== RST_PC || pop_at(0) !== {RST_PC, mem_word(RST_PC)}) begin
      bad++; $display("FAIL late_rsp got=%h/%h want=%h/%h", acc_at(0), pop_at(0), RST_PC, {RST_PC, mem_word(RST_PC)});
    end
  endtask

  task automatic test_random();
    logic [63:0] m_q [$];
    logic [31:0] m_pc, m_out_pc, old_pc, tgt, dat;
    bit          m_mis, m_out, m_squash, m_first, pc_chg, exp_rv, acc, rdy, ifr, rdr, rsp;
    int          rsp_cnt, bad0;
    apply_reset();
    m_pc = RST_PC; m_out_pc = RST_PC; m_mis = 0; m_out = 0; m_squash = 0;
    m_first = 1; pc_chg = 0; rsp_cnt = 0; bad0 = bad;
    for (int cyc = 0; cyc < 4000 && (bad - bad0) < 20; cyc++) begin
      exp_rv = !m_first && !m_out && (m_q.size() < int'(DEPTH)) && !m_mis;
      total++;
      if (imem_req_valid !== exp_rv) begin
        bad++; $display("FAIL rnd_req_valid cyc=%0d got=%b want=%b", cyc, imem_req_valid, exp_rv);
      end
      if (exp_rv) begin
        total++;
        if (imem_req_addr !== m_pc) begin
          bad++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", cyc, imem_req_addr, m_pc);
        end
      end
      total++;
      if (if_valid !== (m_q.size() != 0)) begin
        bad++; $display("FAIL rnd_if_valid cyc=%0d got=%b want=%b", cyc, if_valid, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        total++;
        if ({if_pc, if_instr} !== m_q[0]) begin
          bad++; $display("FAIL rnd_head cyc=%0d got=%h want=%h", cyc, {if_pc, if_instr}, m_q[0]);
        end
      end
      total++;
      if (misalign_o !== m_mis) begin
        bad++; $display("FAIL rnd_misalign cyc=%0d got=%b want=%b", cyc, misalign_o, m_mis);
      end
      total++;
      if (PC_Hold !== !pc_chg) begin
        bad++; $display("FAIL rnd_pc_hold cyc=%0d got=%b want=%b", cyc, PC_Hold, !pc_chg);
      end
      if (pc_chg) begin
        total++;
        if (PC_i !== m_pc) begin
          bad++; $display("FAIL rnd_pc_i cyc=%0d got=%h want=%h", cyc, PC_i, m_pc);
        end
      end

      rdy = ($urandom_range(0, 3) != 0);
      ifr = ($urandom_range(0, 2) != 0);
      rdr = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       tgt = 32'hFFFF_FFF8;
        1:       tgt = RST_PC + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(1, 3));
        default: tgt = RST_PC + 32'($urandom_range(0, 255) * 4);
      endcase
      dat = $urandom;
      rsp = 1'b0;
      if (m_out) begin
        if (rsp_cnt == 0) rsp = 1'b1;
        else rsp_cnt--;
      end else if ($urandom_range(0, 9) == 0) begin
        rsp = 1'b1;
      end
      imem_req_ready = rdy;
      if_ready       = ifr;
      redirect_valid = rdr;
      redirect_pc    = tgt;
      imem_rsp_valid = rsp;
      imem_rsp_data  = dat;

      acc    = exp_rv && rdy;
      old_pc = m_pc;
      if (rdr) begin
        m_q.delete();
        if (tgt[1:0] != 2'b00) m_mis = 1'b1;
        else begin m_mis = 1'b0; m_pc = tgt; end
        m_out    = (m_out && !rsp) || acc;
        m_squash = m_out;
      end else begin
        if (ifr && m_q.size() != 0) void'(m_q.pop_front());
        if (m_out && rsp) begin
          if (!m_squash) m_q.push_back({m_out_pc, dat});
          m_out = 1'b0;
          m_squash = 1'b0;
        end else if (acc) begin
          m_out    = 1'b1;
          m_out_pc = m_pc;
          m_pc     = m_pc + 32'd4;
        end
      end
      if (acc) rsp_cnt = $urandom_range(0, 2);
      m_first = 1'b0;
      pc_chg  = (m_pc != old_pc);
      tick();
    end
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_misalign();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
